// File: rtl/fft_result_serializer.sv
// fft_result_serializer: captures a parallel 16-point complex frame into one of two
// ping-pong banks and streams it out one sample per cycle, optionally in bit-reversed lane order.
`default_nettype none

module fft_result_serializer #(
   parameter int N_POINTS    = 16,
   parameter int DATA_W      = 16,
   parameter bit BIT_REVERSE = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_POINTS*DATA_W-1:0] in_real,
   input  logic [N_POINTS*DATA_W-1:0] in_imag,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [DATA_W-1:0]          out_real,
   output logic [DATA_W-1:0]          out_imag,
   output logic [3:0]                 out_index,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic                       out_last
);

   logic [N_POINTS*DATA_W-1:0] re_q [2];
   logic [N_POINTS*DATA_W-1:0] im_q [2];

   logic [1:0] full_q, full_d;
   logic       wr_bank_q, wr_bank_d;
   logic       rd_bank_q, rd_bank_d;
   logic [3:0] rd_idx_q, rd_idx_d;

   logic       capture;
   logic       beat;
   logic       last_beat;
   logic [3:0] lane;

   assign in_ready  = !full_q[wr_bank_q];
   assign out_valid = full_q[rd_bank_q];
   assign capture   = in_valid && in_ready;
   assign beat      = out_valid && out_ready;
   assign last_beat = beat && (rd_idx_q == 4'd15);

   // Natural-order index n maps to the lane holding frequency bin n.
   assign lane = BIT_REVERSE ? {rd_idx_q[0], rd_idx_q[1], rd_idx_q[2], rd_idx_q[3]}
                             : rd_idx_q;

   assign out_real  = re_q[rd_bank_q][int'(lane)*DATA_W +: DATA_W];
   assign out_imag  = im_q[rd_bank_q][int'(lane)*DATA_W +: DATA_W];
   assign out_index = rd_idx_q;
   assign out_last  = out_valid && (rd_idx_q == 4'd15);

   always_comb begin
      full_d    = full_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      rd_idx_d  = rd_idx_q;
      if (capture) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = !wr_bank_q;
      end
      // A capture never targets the bank being drained, so both updates can coexist.
      if (beat) begin
         rd_idx_d = rd_idx_q + 4'd1;
         if (last_beat) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q    <= 2'b00;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_idx_q  <= 4'd0;
      end else begin
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         rd_idx_q  <= rd_idx_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int b = 0; b < 2; b++) begin
            re_q[b] <= '0;
            im_q[b] <= '0;
         end
      end else if (capture) begin
         re_q[wr_bank_q] <= in_real;
         im_q[wr_bank_q] <= in_imag;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fft_result_serializer.sv
// Directed self-checking bench for fft_result_serializer (bit-reversed and natural-order builds).
`default_nettype none

module tb_fft_result_serializer;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] in_real, in_imag;
   logic         in_valid;
   logic         out_ready;

   logic         in_ready, out_valid, out_last;
   logic [15:0]  out_real, out_imag;
   logic [3:0]   out_index;

   logic         in_ready0, out_valid0, out_last0;
   logic [15:0]  out_real0, out_imag0;
   logic [3:0]   out_index0;

   int n_pass = 0;
   int n_chk  = 0;

   // Expected real values at natural index n for lane k = k+1 under bit reversal.
   int br_exp [16] = '{1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16};
   int rdy_pat [4] = '{1, 0, 0, 1};

   always #5 clk = ~clk;

   fft_result_serializer #(.N_POINTS(16), .DATA_W(16), .BIT_REVERSE(1'b1)) dut (
      .clk(clk), .rst(rst), .in_real(in_real), .in_imag(in_imag),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_real(out_real), .out_imag(out_imag), .out_index(out_index),
      .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
   );

   fft_result_serializer #(.N_POINTS(16), .DATA_W(16), .BIT_REVERSE(1'b0)) dut_nat (
      .clk(clk), .rst(rst), .in_real(in_real), .in_imag(in_imag),
      .in_valid(in_valid), .in_ready(in_ready0),
      .out_real(out_real0), .out_imag(out_imag0), .out_index(out_index0),
      .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0)
   );

   function automatic logic [255:0] frame(input logic [15:0] base);
      logic [255:0] f;
      for (int k = 0; k < 16; k++) f[k*16 +: 16] = base + 16'(k);
      return f;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      int cyc;
      logic [15:0] hold_re;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_real   = frame(16'h5555);
      in_imag   = frame(16'h6666);
      tick();
      tick();
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_out_real",  32'(out_real),  32'd0);
      chk("rst_out_imag",  32'(out_imag),  32'd0);
      rst = 1'b0;
      tick();

      // Single frame: lane k real=k+1, imag=100+k.
      in_real   = frame(16'd1);
      in_imag   = frame(16'd100);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("sf_valid", 32'(out_valid), 32'd1);
         chk("sf_index", 32'(out_index), 32'(i));
         chk("sf_real",  32'(out_real),  32'(br_exp[i]));
         chk("sf_imag",  32'(out_imag),  32'(br_exp[i] + 99));
         chk("sf_last",  32'(out_last),  32'(i == 15));
         chk("nat_real", 32'(out_real0), 32'(i + 1));
         chk("nat_imag", 32'(out_imag0), 32'(i + 100));
         chk("nat_last", 32'(out_last0), 32'(i == 15));
         tick();
      end
      chk("sf_done_valid",  32'(out_valid),  32'd0);
      chk("nat_done_valid", 32'(out_valid0), 32'd0);

      // Back-to-back: A then B two edges later; a third frame is offered while both banks are full.
      in_real  = frame(16'd1);
      in_imag  = frame(16'd100);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("bb_a0_real", 32'(out_real), 32'd1);
      tick();
      in_real  = frame(16'h8000);
      in_imag  = frame(16'h4000);
      in_valid = 1'b1;
      chk("bb_ready_b", 32'(in_ready), 32'd1);
      chk("bb_a1_real", 32'(out_real), 32'd9);
      tick();
      in_real = frame(16'h7777);
      in_imag = frame(16'h7777);
      for (int j = 2; j < 32; j++) begin
         chk("bb_valid", 32'(out_valid), 32'd1);
         chk("bb_index", 32'(out_index), 32'(j % 16));
         if (j < 16) begin
            chk("bb_a_real", 32'(out_real), 32'(br_exp[j]));
            chk("bb_full_ready", 32'(in_ready), 32'd0);
         end else begin
            chk("bb_b_real", 32'(out_real), 32'h8000 + 32'(br_exp[j-16] - 1));
            chk("bb_b_imag", 32'(out_imag), 32'h4000 + 32'(br_exp[j-16] - 1));
         end
         in_valid = (j < 15);
         tick();
      end
      in_valid = 1'b0;
      chk("bb_done_valid", 32'(out_valid), 32'd0);

      // Backpressure: out_ready follows 1,0,0,1,... across the frame.
      in_real  = frame(16'd1);
      in_imag  = frame(16'd100);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      idx      = 0;
      cyc      = 0;
      hold_re  = 16'd0;
      while (idx < 16 && cyc < 80) begin
         out_ready = rdy_pat[cyc % 4][0];
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_index", 32'(out_index), 32'(idx));
         chk("bp_real",  32'(out_real),  32'(br_exp[idx]));
         chk("bp_imag",  32'(out_imag),  32'(br_exp[idx] + 99));
         if (cyc > 0 && rdy_pat[(cyc - 1) % 4] == 0)
            chk("bp_hold", 32'(out_real), 32'(hold_re));
         hold_re = out_real;
         tick();
         if (out_ready) idx++;
         cyc++;
      end
      chk("bp_count", 32'(idx), 32'd16);
      out_ready = 1'b1;
      chk("bp_done_valid", 32'(out_valid), 32'd0);

      // Reset at beat 7 with a second frame queued.
      in_real  = frame(16'd1);
      in_imag  = frame(16'd100);
      in_valid = 1'b1;
      tick();
      in_real = frame(16'h8000);
      in_imag = frame(16'h4000);
      chk("mr_ready_q", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("mr_index7", 32'(out_index), 32'd7);
      chk("mr_full_ready", 32'(in_ready), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_rst_valid", 32'(out_valid), 32'd0);
      chk("mr_rst_ready", 32'(in_ready),  32'd1);
      chk("mr_rst_index", 32'(out_index), 32'd0);
      chk("mr_rst_real",  32'(out_real),  32'd0);
      tick();
      rst = 1'b0;
      tick();
      in_real  = frame(16'h1000);
      in_imag  = frame(16'h2000);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         chk("mr_new_valid", 32'(out_valid), 32'd1);
         chk("mr_new_index", 32'(out_index), 32'(i));
         chk("mr_new_real",  32'(out_real),  32'h1000 + 32'(br_exp[i] - 1));
         tick();
      end
      chk("mr_done_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fft_result_serializer.md
# fft_result_serializer

Collects the parallel 16-point complex result set produced by the final `butterfly_block` stage and streams it out one complex sample per cycle in natural frequency order. It is the consumer end of the `butterfly_block` output bus. Two internal frame banks (ping-pong) let a new parallel result be captured while the previous frame is still draining, so back-to-back frames stream with no bubble.

## Interface
Parameters:
- `N_POINTS`, 16: samples per frame. Fixed at 16; other values are unsupported.
- `DATA_W`, 16: width of each real and each imaginary component, in two's complement.
- `BIT_REVERSE`, 1: if 1, emit lane `bitrev4(n)` at step n. If 0, emit lane n at step n.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_real` in 256: 16 lanes × `DATA_W`. Lane k occupies bits [16k+15:16k] and carries `output_{k+1}_real`.
- `in_imag` in 256: same lane packing, carries `output_{k+1}_imaginary`.
- `in_valid` in 1: the parallel frame on `in_real`/`in_imag` is valid.
- `in_ready` out 1: the write bank is empty and a capture will be accepted.
- `out_real` out 16: real part of the current serial sample.
- `out_imag` out 16: imaginary part of the current serial sample.
- `out_index` out 4: natural-order index n of the current sample.
- `out_valid` out 1: the serial sample is valid.
- `out_ready` in 1: the downstream block accepts the sample.
- `out_last` out 1: high when `out_index` = 15 and `out_valid` = 1.

## Operation
- Storage: two banks, each holding 16 × (real, imag). Each bank has a full flag.
- Pointers: `wr_bank` (1 bit), `rd_bank` (1 bit), `rd_idx` (4 bits).
- Capture: when `in_valid && in_ready` at a rising edge, all 32 words are written into `wr_bank`. That bank's full flag is set and `wr_bank` toggles. With `in_ready` low, `in_valid` is ignored and no data is lost or corrupted.
- `in_ready` = !full[`wr_bank`], decoded combinationally from registers. It does not depend on `in_valid` or `out_ready`.
- `out_valid` = full[`rd_bank`].
- `out_real`/`out_imag` = bank[`rd_bank`] at lane L. L = `bitrev4(rd_idx)` when `BIT_REVERSE`=1, else L = `rd_idx`.
- `out_index` = `rd_idx`.
- Beat transfer: when `out_valid && out_ready`, `rd_idx` increments.
- Frame drain: when the transferred beat has `rd_idx` = 15, `rd_idx` wraps to 0, full[`rd_bank`] clears, and `rd_bank` toggles.
- Simultaneous capture and last beat on different banks: both actions take effect at the same edge.
- Simultaneous capture and last beat on the same bank cannot occur: a full bank never has `in_ready` high.
- No bypass: a bank freed at edge t reports `in_ready` from cycle t+1.
- Data is passed through unmodified; there is no scaling or rounding.

## Timing
- Reset (asynchronous assert, synchronous release):
  - Both full flags are 0.
  - `wr_bank`, `rd_bank` and `rd_idx` are 0.
  - Storage is cleared to 0.
  - Output values during reset: `in_ready`=1, `out_valid`=0, `out_last`=0, `out_index`=0, `out_real`=0, `out_imag`=0.
- Reset mid-frame: the frame in progress and any queued frame are discarded. The block returns to the reset state immediately.
- Latency: a capture at edge t gives `out_valid`=1 in cycle t+1, provided that bank is next in read order.
- Throughput: 1 sample per cycle while `out_ready`=1.
  - Frame B captured during the drain of frame A is output the cycle after A's last beat, with no idle cycle.
- Backpressure: while `out_valid && !out_ready`, all of `out_*` hold stable.
- Both banks full: `in_ready`=0 until the last beat of the current read bank has transferred.

## Test plan
- Reset check: assert `rst` → `in_ready`=1, `out_valid`=0, and all output data = 0.
- Single frame, `BIT_REVERSE`=1: capture lane k real=k+1, imag=100+k, with `out_ready`=1.
  - Beats start 1 cycle after capture and run 16 consecutive cycles.
  - Expected real sequence: 1, 9, 5, 13, 3, 11, 7, 15, 2, 10, 6, 14, 4, 12, 8, 16. Imag follows the same lanes.
  - `out_last` is high only on beat 16.
- Back-to-back frames: capture frame A, then frame B (lane k real=0x8000+k) 2 cycles later.
  - 32 contiguous beats; B's first beat (real 0x8000) immediately follows A's last.
  - A third `in_valid` while both banks are full gives `in_ready`=0 and is ignored.
- Backpressure: toggle `out_ready` 1,0,0,1,... mid-frame.
  - Held beats repeat identical `out_real`/`out_imag`/`out_index` values.
  - No sample is skipped or duplicated in the transferred sequence.
- Reset mid-frame: assert `rst` at beat 7 of a frame with a second frame queued.
  - `out_valid`=0 immediately and `in_ready`=1 immediately.
  - After release, a new capture streams from index 0.
- `BIT_REVERSE`=0 build: same stimulus as the single-frame scenario → reals 1..16 in lane order.
